// File: rtl/reorder_buffer_if.sv
// Bundles the decode-allocation, CDB-broadcast and commit signals of the
// reorder buffer. The master side issues requests and broadcasts; the
// slave side is the buffer itself.
//
// Handshake: robReq is a request, not a valid/ready pair. It is accepted at a
// rising edge only when fullRob=0 and controlFlow=0 in that same cycle. The
// tag it receives is the robAllocation value seen in that cycle. A commit is
// offered whenever validCommit=1 and retires unconditionally at the edge.
interface reorder_buffer_if #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int REG   = 4,
    parameter int INDEX = 7
);
    // allocation side
    logic             robReq;
    logic [3:0]       allocInfo;
    logic [REG:0]     allocDest;
    logic [WIDTH:0]   allocPC;
    logic [INDEX:0]   allocPHT;
    logic [WIDTH:0]   allocStatus;
    // common data bus
    logic             cdbValid;
    logic [ROB:0]     cdbROB;
    logic [WIDTH:0]   cdbResult;
    logic             cdbMispredict;
    logic [WIDTH:0]   cdbTarget;
    // buffer outputs
    logic [ROB:0]     robAllocation;
    logic             fullRob;
    logic             validCommit;
    logic [ROB:0]     commitROB;
    logic [REG:0]     destCommit;
    logic [WIDTH:0]   result;
    logic [3:0]       commitInfo;
    logic [INDEX:0]   commitPHT;
    logic [WIDTH:0]   statusSnap;
    logic             controlFlow;
    logic [WIDTH:0]   redirectPC;

    modport master (
        output robReq, allocInfo, allocDest, allocPC, allocPHT, allocStatus,
        output cdbValid, cdbROB, cdbResult, cdbMispredict, cdbTarget,
        input  robAllocation, fullRob, validCommit, commitROB, destCommit,
        input  result, commitInfo, commitPHT, statusSnap, controlFlow, redirectPC
    );

    modport slave (
        input  robReq, allocInfo, allocDest, allocPC, allocPHT, allocStatus,
        input  cdbValid, cdbROB, cdbResult, cdbMispredict, cdbTarget,
        output robAllocation, fullRob, validCommit, commitROB, destCommit,
        output result, commitInfo, commitPHT, statusSnap, controlFlow, redirectPC
    );
endinterface

// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer. Entries are allocated in order at the
// tail, completed out of order by CDB broadcasts, and retired in order from
// the head. A retiring mispredicted control-flow instruction raises
// controlFlow for its commit cycle and empties the whole buffer at that edge.
module reorder_buffer #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int REG   = 4,
    parameter int INDEX = 7
) (
    input  logic             clk,
    input  logic             globalReset,
    reorder_buffer_if.slave  bus
);
    localparam int DEPTH = 2 ** (ROB + 1);
    localparam logic [ROB+1:0] FULL_COUNT = (ROB + 2)'(DEPTH);

    typedef logic [ROB:0] tag_t;

    // per-entry state
    logic           valid_q      [DEPTH];
    logic           valid_d      [DEPTH];
    logic           ready_q      [DEPTH];
    logic           ready_d      [DEPTH];
    logic           mispredict_q [DEPTH];
    logic           mispredict_d [DEPTH];
    logic [3:0]     info_q       [DEPTH];
    logic [3:0]     info_d       [DEPTH];
    logic [REG:0]   dest_q       [DEPTH];
    logic [REG:0]   dest_d       [DEPTH];
    logic [INDEX:0] pht_q        [DEPTH];
    logic [INDEX:0] pht_d        [DEPTH];
    logic [WIDTH:0] status_q     [DEPTH];
    logic [WIDTH:0] status_d     [DEPTH];
    logic [WIDTH:0] value_q      [DEPTH];
    logic [WIDTH:0] value_d      [DEPTH];
    logic [WIDTH:0] target_q     [DEPTH];
    logic [WIDTH:0] target_d     [DEPTH];

    // pointers and occupancy
    tag_t           head_q, head_d;
    tag_t           tail_q, tail_d;
    logic [ROB+1:0] count_q, count_d;

    logic full;
    logic valid_commit;
    logic control_flow;
    logic do_alloc;

    // Head retirement and flush decode; the allocation gate depends on both.
    always_comb begin
        full         = (count_q == FULL_COUNT);
        valid_commit = valid_q[head_q] & ready_q[head_q];
        control_flow = valid_commit & mispredict_q[head_q];
        do_alloc     = bus.robReq & ~full & ~control_flow;
    end

    // Next-state: a flush overrides everything, otherwise CDB completion,
    // head retirement and tail allocation are applied in that order so the
    // later updates win on any shared entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i]      = valid_q[i];
            ready_d[i]      = ready_q[i];
            mispredict_d[i] = mispredict_q[i];
            info_d[i]       = info_q[i];
            dest_d[i]       = dest_q[i];
            pht_d[i]        = pht_q[i];
            status_d[i]     = status_q[i];
            value_d[i]      = value_q[i];
            target_d[i]     = target_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (control_flow) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i]      = 1'b0;
                ready_d[i]      = 1'b0;
                mispredict_d[i] = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (bus.cdbValid && valid_q[bus.cdbROB]) begin
                ready_d[bus.cdbROB]      = 1'b1;
                value_d[bus.cdbROB]      = bus.cdbResult;
                mispredict_d[bus.cdbROB] = bus.cdbMispredict;
                target_d[bus.cdbROB]     = bus.cdbTarget;
            end
            if (valid_commit) begin
                valid_d[head_q]      = 1'b0;
                ready_d[head_q]      = 1'b0;
                mispredict_d[head_q] = 1'b0;
                head_d               = head_q + tag_t'(1);
            end
            if (do_alloc) begin
                valid_d[tail_q]      = 1'b1;
                ready_d[tail_q]      = 1'b0;
                mispredict_d[tail_q] = 1'b0;
                info_d[tail_q]       = bus.allocInfo;
                dest_d[tail_q]       = bus.allocDest;
                pht_d[tail_q]        = bus.allocPHT;
                status_d[tail_q]     = bus.allocStatus;
                tail_d               = tail_q + tag_t'(1);
            end
            case ({do_alloc, valid_commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset empties the buffer immediately.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]      <= 1'b0;
                ready_q[i]      <= 1'b0;
                mispredict_q[i] <= 1'b0;
                info_q[i]       <= '0;
                dest_q[i]       <= '0;
                pht_q[i]        <= '0;
                status_q[i]     <= '0;
                value_q[i]      <= '0;
                target_q[i]     <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]      <= valid_d[i];
                ready_q[i]      <= ready_d[i];
                mispredict_q[i] <= mispredict_d[i];
                info_q[i]       <= info_d[i];
                dest_q[i]       <= dest_d[i];
                pht_q[i]        <= pht_d[i];
                status_q[i]     <= status_d[i];
                value_q[i]      <= value_d[i];
                target_q[i]     <= target_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Output drive; commit fields read zero whenever nothing retires.
    always_comb begin
        bus.robAllocation = tail_q;
        bus.fullRob       = full;
        bus.validCommit   = valid_commit;
        bus.controlFlow   = control_flow;
        bus.commitROB     = valid_commit ? head_q           : '0;
        bus.destCommit    = valid_commit ? dest_q[head_q]   : '0;
        bus.result        = valid_commit ? value_q[head_q]  : '0;
        bus.commitInfo    = valid_commit ? info_q[head_q]   : '0;
        bus.commitPHT     = valid_commit ? pht_q[head_q]    : '0;
        bus.statusSnap    = valid_commit ? status_q[head_q] : '0;
        bus.redirectPC    = control_flow ? target_q[head_q] : '0;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/overflow, out-of-order completion,
// full-with-commit, mispredict flush, pointer wrap and mid-run reset.
module tb_reorder_buffer;
    logic clk;
    logic global_reset;
    int   checks;
    int   errors;

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk         (clk),
        .globalReset (global_reset),
        .bus         (rif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic idle();
        rif.robReq        = 1'b0;
        rif.allocInfo     = 4'd0;
        rif.allocDest     = 5'd0;
        rif.allocPC       = 32'd0;
        rif.allocPHT      = 8'd0;
        rif.allocStatus   = 32'd0;
        rif.cdbValid      = 1'b0;
        rif.cdbROB        = 3'd0;
        rif.cdbResult     = 32'd0;
        rif.cdbMispredict = 1'b0;
        rif.cdbTarget     = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        global_reset = 1'b0;
        step();
        global_reset = 1'b1;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] value,
                       input logic mis, input logic [31:0] target);
        rif.cdbValid      = 1'b1;
        rif.cdbROB        = tag;
        rif.cdbResult     = value;
        rif.cdbMispredict = mis;
        rif.cdbTarget     = target;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        global_reset = 1'b0;
        idle();
        @(negedge clk);
        #1;
        // reset state
        check("rst_full",   32'(rif.fullRob), 32'd0);
        check("rst_alloc",  32'(rif.robAllocation), 32'd0);
        check("rst_commit", 32'(rif.validCommit), 32'd0);
        check("rst_cf",     32'(rif.controlFlow), 32'd0);
        check("rst_result", rif.result, 32'd0);
        step();
        global_reset = 1'b1;

        // fill eight entries, then a ninth request is ignored
        for (int i = 0; i < 8; i++) begin
            idle();
            rif.robReq    = 1'b1;
            rif.allocDest = 5'(i);
            #1;
            check("fill_tag",  32'(rif.robAllocation), 32'(i));
            check("fill_full", 32'(rif.fullRob), 32'd0);
            step();
        end
        idle();
        #1;
        check("full_set",  32'(rif.fullRob), 32'd1);
        check("full_tail", 32'(rif.robAllocation), 32'd0);
        rif.robReq = 1'b1;
        step();
        idle();
        #1;
        check("ovf_full",   32'(rif.fullRob), 32'd1);
        check("ovf_tail",   32'(rif.robAllocation), 32'd0);
        check("ovf_commit", 32'(rif.validCommit), 32'd0);

        // full buffer: commit and request in one cycle, request is dropped
        cdb(3'd0, 32'h11, 1'b0, 32'd0);
        step();
        idle();
        rif.robReq = 1'b1;
        #1;
        check("fc_valid",  32'(rif.validCommit), 32'd1);
        check("fc_tag",    32'(rif.commitROB), 32'd0);
        check("fc_result", rif.result, 32'h11);
        check("fc_full",   32'(rif.fullRob), 32'd1);
        step();
        idle();
        #1;
        check("fc_after_full", 32'(rif.fullRob), 32'd0);
        check("fc_after_tail", 32'(rif.robAllocation), 32'd0);
        check("fc_after_vc",   32'(rif.validCommit), 32'd0);
        rif.robReq = 1'b1;
        step();
        idle();
        #1;
        check("fc_refill_full", 32'(rif.fullRob), 32'd1);
        check("fc_refill_tail", 32'(rif.robAllocation), 32'd1);

        // out-of-order completion, in-order commit
        do_reset();
        rif.robReq      = 1'b1;
        rif.allocInfo   = 4'b1000;
        rif.allocDest   = 5'd5;
        rif.allocPHT    = 8'h12;
        rif.allocStatus = 32'hA5;
        step();
        rif.allocDest   = 5'd6;
        rif.allocPHT    = 8'h34;
        rif.allocStatus = 32'h5A;
        step();
        idle();
        cdb(3'd1, 32'h55, 1'b0, 32'd0);
        step();
        idle();
        cdb(3'd0, 32'hAA, 1'b0, 32'd0);
        #1;
        check("ooo_wait", 32'(rif.validCommit), 32'd0);
        step();
        idle();
        #1;
        check("ooo_c0_valid",  32'(rif.validCommit), 32'd1);
        check("ooo_c0_tag",    32'(rif.commitROB), 32'd0);
        check("ooo_c0_result", rif.result, 32'hAA);
        check("ooo_c0_dest",   32'(rif.destCommit), 32'd5);
        check("ooo_c0_info",   32'(rif.commitInfo), 32'h8);
        check("ooo_c0_pht",    32'(rif.commitPHT), 32'h12);
        check("ooo_c0_status", rif.statusSnap, 32'hA5);
        step();
        #1;
        check("ooo_c1_valid",  32'(rif.validCommit), 32'd1);
        check("ooo_c1_tag",    32'(rif.commitROB), 32'd1);
        check("ooo_c1_result", rif.result, 32'h55);
        check("ooo_c1_dest",   32'(rif.destCommit), 32'd6);
        step();
        #1;
        check("ooo_empty_vc",  32'(rif.validCommit), 32'd0);
        check("ooo_empty_res", rif.result, 32'd0);
        check("ooo_empty_dst", 32'(rif.destCommit), 32'd0);

        // mispredict at tag 2 with tags 3..5 behind it
        do_reset();
        rif.robReq = 1'b1;
        step();                                   // alloc 0
        step();                                   // alloc 1
        rif.allocInfo = 4'b1010;
        rif.allocDest = 5'd9;
        cdb(3'd0, 32'd1, 1'b0, 32'd0);
        step();                                   // alloc 2, complete 0
        rif.allocInfo = 4'b0000;
        rif.allocDest = 5'd0;
        cdb(3'd1, 32'd2, 1'b0, 32'd0);
        step();                                   // alloc 3, complete 1, commit 0
        rif.cdbValid = 1'b0;
        step();                                   // alloc 4, commit 1
        cdb(3'd2, 32'h33, 1'b1, 32'h100);
        #1;
        check("mp_alloc5", 32'(rif.robAllocation), 32'd5);
        step();                                   // alloc 5, complete 2
        cdb(3'd3, 32'h77, 1'b0, 32'd0);           // must be dropped by the flush
        #1;
        check("mp_cf",       32'(rif.controlFlow), 32'd1);
        check("mp_redirect", rif.redirectPC, 32'h100);
        check("mp_vc",       32'(rif.validCommit), 32'd1);
        check("mp_tag",      32'(rif.commitROB), 32'd2);
        check("mp_result",   rif.result, 32'h33);
        check("mp_dest",     32'(rif.destCommit), 32'd9);
        check("mp_info",     32'(rif.commitInfo), 32'hA);
        step();
        idle();
        #1;
        check("mp_after_cf",    32'(rif.controlFlow), 32'd0);
        check("mp_after_redir", rif.redirectPC, 32'd0);
        check("mp_after_tail",  32'(rif.robAllocation), 32'd0);
        check("mp_after_vc",    32'(rif.validCommit), 32'd0);
        check("mp_after_full",  32'(rif.fullRob), 32'd0);
        // a count of zero means exactly eight more allocations fill it
        for (int i = 0; i < 8; i++) begin
            rif.robReq = 1'b1;
            #1;
            check("mp_refill_full", 32'(rif.fullRob), 32'd0);
            step();
        end
        idle();
        #1;
        check("mp_refill_done", 32'(rif.fullRob), 32'd1);

        // ten allocate/complete/commit pairs, pointers wrap 7 -> 0
        do_reset();
        for (int k = 0; k < 12; k++) begin
            idle();
            if (k < 10) begin
                rif.robReq    = 1'b1;
                rif.allocDest = 5'(k);
            end
            if (k >= 1 && k <= 10)
                cdb(3'((k - 1) % 8), 32'h1000 + 32'(k - 1), 1'b0, 32'd0);
            #1;
            if (k < 10)
                check("wrap_alloc", 32'(rif.robAllocation), 32'(k % 8));
            if (k >= 2) begin
                check("wrap_vc",     32'(rif.validCommit), 32'd1);
                check("wrap_tag",    32'(rif.commitROB), 32'((k - 2) % 8));
                check("wrap_result", rif.result, 32'h1000 + 32'(k - 2));
                check("wrap_dest",   32'(rif.destCommit), 32'(k - 2));
            end
            step();
        end
        idle();
        #1;
        check("wrap_end_vc", 32'(rif.validCommit), 32'd0);

        // reset with five entries in flight
        do_reset();
        rif.robReq = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle();
        cdb(3'd0, 32'h22, 1'b0, 32'd0);
        step();
        idle();
        #1;
        check("mr_pre_vc",  32'(rif.validCommit), 32'd1);
        check("mr_pre_tag", 32'(rif.robAllocation), 32'd5);
        global_reset = 1'b0;
        #1;
        check("mr_vc",    32'(rif.validCommit), 32'd0);
        check("mr_full",  32'(rif.fullRob), 32'd0);
        check("mr_alloc", 32'(rif.robAllocation), 32'd0);
        step();
        global_reset = 1'b1;
        rif.robReq = 1'b1;
        #1;
        check("mr_first_tag", 32'(rif.robAllocation), 32'd0);
        step();
        idle();
        #1;
        check("mr_next_tag", 32'(rif.robAllocation), 32'd1);
        check("mr_next_vc",  32'(rif.validCommit), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 31: data and PC MSB index.
REQ-002 The block SHALL have parameter ROB, default 2: tag MSB index, giving 8 entries.
REQ-003 The block SHALL have parameter REG, default 4: architectural register index MSB.
REQ-004 The block SHALL have parameter INDEX, default 7: PHT index MSB.
Ports:
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 globalReset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 robReq  in  1  allocation request from decode.
REQ-008 allocInfo  in  4  {regWrite,memWrite,branch,jalr} of the allocating instruction.
REQ-009 allocDest  in  REG+1  destination register.
REQ-010 allocPC  in  WIDTH+1  instruction PC.
REQ-011 allocPHT  in  INDEX+1  PHT index.
REQ-012 allocStatus  in  WIDTH+1  register-status snapshot.
REQ-013 cdbValid  in  1  CDB broadcast valid.
REQ-014 cdbROB  in  ROB+1  broadcast tag.
REQ-015 cdbResult  in  WIDTH+1  broadcast result.
REQ-016 cdbMispredict  in  1  control-flow mispredicted.
REQ-017 cdbTarget  in  WIDTH+1  corrected PC.
REQ-018 robAllocation  out  ROB+1  tag assigned to the current request (tail).
REQ-019 fullRob  out  1  no free entry.
REQ-020 validCommit  out  1  head entry retires this cycle.
REQ-021 commitROB  out  ROB+1  retiring tag.
REQ-022 destCommit  out  REG+1  retiring destination.
REQ-023 result  out  WIDTH+1  retiring value.
REQ-024 commitInfo  out  4  retiring allocInfo.
REQ-025 commitPHT  out  INDEX+1  retiring PHT index.
REQ-026 statusSnap  out  WIDTH+1  retiring status snapshot.
REQ-027 controlFlow  out  1  flush; high for exactly the mispredict-commit cycle.
REQ-028 redirectPC  out  WIDTH+1  restart PC, valid with controlFlow.

Function
REQ-029 The block SHALL be an 8-entry circular buffer with head and tail pointers (ROB+1 bits) and an occupancy count (ROB+2 bits).
REQ-030 fullRob SHALL be combinational and equal to (count==8); robAllocation SHALL equal tail.
REQ-031 robReq with fullRob=0 and controlFlow=0 SHALL, at the edge, write the entry at tail with valid=1 and ready=0, and advance tail modulo 8 (7->0).
REQ-032 robReq with fullRob=1 SHALL be ignored, with no state change; a commit in the same cycle SHALL NOT make room for it.
REQ-033 cdbValid to a valid entry SHALL set ready=1 and store cdbResult, cdbMispredict and cdbTarget; cdbValid to an invalid entry SHALL be ignored.
REQ-034 validCommit SHALL be combinational: head valid and ready.
REQ-035 While validCommit=1, the commit outputs SHALL reflect the head entry; otherwise they SHALL be 0.
REQ-036 Each validCommit SHALL clear the head entry and advance head modulo 8 at the edge.
REQ-037 A CDB write to the head SHALL commit no earlier than the following cycle, because ready is registered.
REQ-038 Allocate and commit in the same cycle SHALL leave count unchanged.
REQ-039 A committing head with its mispredict flag set SHALL assert controlFlow and drive redirectPC=target in that cycle, and SHALL still present its register write.
REQ-040 At the edge following controlFlow, the block SHALL invalidate all entries, set head=tail=count=0, and ignore that cycle's robReq and CDB writes.
REQ-041 Throughput SHALL be at most one allocation and one commit per cycle.

Reset
REQ-042 globalReset=0 SHALL immediately clear all valid and ready bits and set head, tail and count to 0, giving fullRob=0, robAllocation=0, validCommit=0, controlFlow=0 and all commit outputs 0.
REQ-043 Reset asserted mid-operation SHALL discard all in-flight entries; the first allocation after release SHALL receive tag 0.

Verification
REQ-044 Allocate 8 times with no commits -> tags 0..7 issued, fullRob=1; a 9th robReq changes no state.
REQ-045 Allocate tags 0,1; CDB tag 1 result 0x55; CDB tag 0 result 0xAA -> commit tag 0 (0xAA), then tag 1 (0x55) on consecutive cycles.
REQ-046 Full buffer; commit head and robReq in the same cycle -> request ignored, count=7, fullRob=0 next cycle.
REQ-047 Tag 2 at head with mispredict, target 0x100, tags 3-5 allocated -> controlFlow=1 and redirectPC=0x100 for one cycle, then count=0 and robAllocation=0.
REQ-048 Perform 10 allocate/commit pairs -> tail wraps 7->0 and commitROB sequence is 0..7,0,1.
REQ-049 Assert reset with 5 entries valid -> validCommit=0 and fullRob=0 immediately; next allocation receives tag 0.
